// File: rtl/mips_mul_unit.sv
// Iterative shift-add multiplier for the MUL instruction in EX.
// Stalls the pipeline for WIDTH+1 cycles and presents a registered 2*WIDTH-bit product for one done cycle.
module mips_mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             abort,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic               r_neg;
  logic [2*WIDTH:0]   r_acc;
  logic [CW-1:0]      r_cnt;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH:0]   w_acc_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_final;

  assign w_accept = (r_state == IDLE) && start && !abort;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // The most negative operand negates to itself, which read as unsigned is exactly its magnitude.
  assign w_mag_a = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign w_mag_b = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;

  // Top accumulator bit is always clear before the add, so the upper half never overflows WIDTH+1 bits.
  assign w_sum      = r_acc[2*WIDTH:WIDTH] + (r_mplier[0] ? {1'b0, r_mcand} : '0);
  assign w_acc_next = {w_sum, r_acc[WIDTH-1:0]} >> 1;
  assign w_prod     = w_acc_next[2*WIDTH-1:0];
  assign w_final    = r_neg ? -w_prod : w_prod;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    stall  = 1'b0;
    case (r_state)
      IDLE: begin
        stall = w_accept;
        if (w_accept) w_next = RUN;
      end
      RUN: begin
        busy  = 1'b1;
        stall = 1'b1;
        if (abort)       w_next = IDLE;
        else if (w_last) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_neg     <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      result_lo <= '0;
      result_hi <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mcand  <= w_mag_a;
            r_mplier <= w_mag_b;
            r_neg    <= is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        RUN: begin
          if (!abort) begin
            r_acc    <= w_acc_next;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) {result_hi, result_lo} <= w_final;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mul_unit.sv
// Self-checking bench for mips_mul_unit: vector table, corner-case sequences and
// randomized operands compared against a plain-arithmetic product model.
module tb_mips_mul_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        abort;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;

  int checks   = 0;
  int failures = 0;

  mips_mul_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .abort     (abort),
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [63:0] exp;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    longint sa;
    longint sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation and leaves the bench in the DONE cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       input logic [63:0] exp, input string name);
    int cyc;
    int stalls;
    op_a      = a;
    op_b      = b;
    is_signed = sgn;
    start     = 1'b1;
    #1;
    stalls = stall ? 1 : 0;
    step();
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 100) begin
      if (stall) stalls++;
      step();
      cyc++;
    end
    check({name, "_latency"}, 64'(cyc), 64'd33);
    check({name, "_stall_cycles"}, 64'(stalls), 64'd33);
    check({name, "_stall_in_done"}, 64'(stall), 64'd0);
    check({name, "_product"}, {result_hi, result_lo}, exp);
  endtask

  task automatic to_idle(input string name);
    step();
    check({name, "_idle_busy"}, 64'(busy), 64'd0);
    check({name, "_idle_done"}, 64'(done), 64'd0);
  endtask

  task automatic start_pulse(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    op_a      = a;
    op_b      = b;
    is_signed = sgn;
    start     = 1'b1;
    step();
    start = 1'b0;
  endtask

  vec_t        vecs[7];
  logic [31:0] chain;
  logic [31:0] ra;
  logic [31:0] rb;
  logic        rs;
  int          done_cnt;

  initial begin
    vecs[0] = '{32'd6,        32'd5,        1'b0, 64'd30,                    "u6x5"};
    vecs[1] = '{32'hFFFFFFFD, 32'd7,        1'b1, 64'hFFFFFFFF_FFFFFFEB,     "s_m3x7"};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001,     "u_max_sq"};
    vecs[3] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000,     "s_min_x_m1"};
    vecs[4] = '{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000,     "s_min_sq"};
    vecs[5] = '{32'h80000000, 32'd2,        1'b0, 64'h00000001_00000000,     "u_msb_x2"};
    vecs[6] = '{32'd0,        32'hDEADBEEF, 1'b1, 64'd0,                     "s_zero"};

    reset = 1'b0; start = 1'b0; abort = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    repeat (3) step();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_lo", 64'(result_lo), 64'd0);
    check("reset_hi", 64'(result_hi), 64'd0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp, vecs[i].name);
      to_idle(vecs[i].name);
    end

    // Factorial chain, each step forwarded from the previous product.
    chain = 32'd1;
    for (int k = 6; k >= 1; k--) begin
      do_op(chain, 32'(k), 1'b0, ref_mul(chain, 32'(k), 1'b0), "fact");
      chain = result_lo;
      to_idle("fact");
    end
    check("fact_final", 64'(result_lo), 64'd720);

    // A second start mid-run is ignored.
    start_pulse(32'd11, 32'd13, 1'b0);
    done_cnt = 0;
    for (int c = 1; c < 45; c++) begin
      start = (c == 10);
      if (c == 10) begin op_a = 32'd99; op_b = 32'd99; end
      if (done) begin
        done_cnt++;
        check("restart_done_cycle", 64'(c), 64'd33);
        check("restart_product", {result_hi, result_lo}, 64'd143);
      end
      step();
    end
    start = 1'b0;
    check("restart_done_count", 64'(done_cnt), 64'd1);
    check("restart_busy_after", 64'(busy), 64'd0);

    // Abort at cycle 10 of a run.
    start_pulse(32'd5, 32'd5, 1'b0);
    repeat (9) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_stall", 64'(stall), 64'd0);
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) done_cnt++;
      step();
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_keeps_result", {result_hi, result_lo}, 64'd143);

    // Abort and start together in IDLE.
    op_a = 32'd2; op_b = 32'd2; start = 1'b1; abort = 1'b1;
    #1;
    check("abort_start_stall", 64'(stall), 64'd0);
    step();
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", 64'(busy), 64'd0);
    check("abort_start_result", {result_hi, result_lo}, 64'd143);

    // Abort during DONE does not disturb the result.
    do_op(32'd7, 32'd8, 1'b0, 64'd56, "abort_in_done");
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_in_done_result", {result_hi, result_lo}, 64'd56);
    check("abort_in_done_busy", 64'(busy), 64'd0);

    // Synchronous reset mid-run.
    start_pulse(32'd3, 32'd3, 1'b0);
    repeat (9) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_stall", 64'(stall), 64'd0);
    check("midrst_result", {result_hi, result_lo}, 64'd0);
    do_op(32'd9, 32'd9, 1'b0, 64'd81, "post_reset_9x9");
    to_idle("post_reset_9x9");

    // Randomized operands against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i % 6 == 0) ra = 32'h80000000;
      if (i % 6 == 1) rb = 32'hFFFFFFFF;
      do_op(ra, rb, rs, ref_mul(ra, rb, rs), "rand");
      to_idle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_mul_unit.md
# mips_mul_unit

Iterative shift-add multiplier serving the MUL instruction (R-type, funct 0x3F) in the EX stage of the pipelined MIPS core. EX hands it two 32-bit operands with a one-cycle start pulse. The unit holds the pipeline with a stall request while it iterates, then presents a 64-bit product for one done cycle so EX/MEM can capture the low word for write-back to rd. It supports signed and unsigned operands and can be aborted on pipeline flush.

## Interface
- WIDTH, 32, operand width. The product is 2*WIDTH bits and the iteration count is WIDTH.
- clk  in  1  pipeline clock. All state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request. Operands are sampled with it. Ignored unless in IDLE.
- is_signed  in  1  1 = two's-complement operands; 0 = unsigned. Sampled with start.
- op_a  in  WIDTH  multiplicand (rs value after forwarding).
- op_b  in  WIDTH  multiplier (rt value after forwarding).
- abort  in  1  pipeline flush. Cancels any operation in progress.
- busy  out  1  high in RUN.
- stall  out  1  combinational: (state==RUN) | (state==IDLE & start & ~abort).
- done  out  1  high for exactly one cycle, in DONE.
- result_lo  out  WIDTH  low half of the product; MUL writes this to rd.
- result_hi  out  WIDTH  high half of the product.

## Operation
- States: IDLE, RUN, DONE. Reset value is IDLE.
- Reset values: busy=0, done=0, result_lo=0, result_hi=0, counter=0, accumulator=0.
- IDLE & start & ~abort:
  - Latch the magnitudes of op_a and op_b. Take the magnitude only if is_signed and the MSB is set.
  - Latch neg = is_signed & (op_a[MSB] ^ op_b[MSB]).
  - Clear the accumulator and counter. Go to RUN.
- RUN, each cycle:
  - If multiplier bit 0 = 1, add the multiplicand to the upper half of the 2*WIDTH+1-bit accumulator.
  - Shift the accumulator and multiplier right by 1. Increment the counter.
- RUN, after the WIDTH-th iteration: go to DONE. Register the product into result_hi:result_lo, two's-complement negated over the full 2*WIDTH bits if neg.
- DONE: done=1, stall=0, so EX/MEM captures result_lo on this edge. Go to IDLE next cycle unconditionally.
- result_lo and result_hi hold their value until the next completed operation. Abort and start do not change them.
- start while in RUN or DONE is ignored. No queueing; the pipeline is responsible for holding the instruction via stall.
- abort in RUN: go to IDLE next edge. done is never asserted for the aborted operation. busy drops on that edge.
- abort and start together in IDLE: the start is ignored and stall=0.
- abort in DONE: no effect. The result is already final.
- reset (low) in any state: forces IDLE and the reset values on the next edge. It overrides start and abort.
- Arithmetic:
  - The magnitude of the most negative input (0x80000000) is 2^31, held in WIDTH bits as unsigned.
  - All products fit in 64 bits with no overflow flag.
  - Unsigned mode never negates.

## Timing
- start sampled at edge E0 means:
  - RUN during cycles E0..E0+WIDTH.
  - DONE (done=1) during the cycle between E0+WIDTH and E0+WIDTH+1.
  - IDLE again after E0+WIDTH+1.
- Latency from start to done is WIDTH+1 = 33 cycles. stall is high for 33 cycles, including the start cycle.
- A back-to-back start is accepted at the earliest in the first IDLE cycle after DONE. Throughput is one product per WIDTH+2 cycles.
- result_* are valid from the DONE cycle onward. They are registered outputs, with no combinational path from the operands.

## Test plan
- Unsigned 6 × 5, start for 1 cycle → stall high for 33 cycles; done at cycle 33; result_lo=30, result_hi=0; busy=0 afterwards.
- Signed -3 (0xFFFFFFFD) × 7 → result_lo=0xFFFFFFEB, result_hi=0xFFFFFFFF. Unsigned 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Signed 0x80000000 × 0xFFFFFFFF (-2^31 × -1) → hi=0x00000000, lo=0x80000000.
- Factorial chain: issue 1×6, then result×5, 4, 3, 2, 1, each started in the IDLE cycle after done → final result_lo=720, with 5 idle/done gap cycles correctly stalled.
- Assert start again at cycle 10 of a run → ignored; the single done and product are unchanged. Abort at cycle 10 → IDLE next edge, no done, result_* keep the previous value.
- Drive reset low mid-RUN for 1 cycle → IDLE, all outputs 0 on the next edge. A subsequent 9 × 9 completes normally with 81.
